// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: E-stage operand forwarding select encodings.
package pipeline_pkg;
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_W   = 2'b01;
  localparam fwd_sel_t FWD_M   = 2'b10;
endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter for hazard performance statistics; holds at all-ones.
module hazard_sat_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + PERF_W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: forwarding selects, RAW/branch stalls, control flushes,
// multi-cycle MDU stall sequencing and saturating stall/flush counters.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_LATENCY = 4,
  parameter bit FWD_EN      = 1'b1,
  parameter int PERF_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic                  branch_d,
  input  logic                  pcsrc_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  reg_write_e,
  input  logic                  mem_read_e,
  input  logic                  mdu_op_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic                  mem_read_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  mdu_done,
  output logic [PERF_W-1:0]     stall_cnt,
  output logic [PERF_W-1:0]     flush_cnt
);

  localparam int CNT_W = $clog2(MDU_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);

  logic [CNT_W-1:0] cnt, cnt_next;
  logic             mdu_stall, raw_stall;
  logic             d_hit_e, d_hit_m;

  // x0 is hardwired zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

  function automatic fwd_sel_t fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (reg_write_m && reg_hit(rd_m, rs)) return FWD_M;
    if (reg_write_w && reg_hit(rd_w, rs)) return FWD_W;
    return FWD_REG;
  endfunction

  assign d_hit_e = reg_hit(rd_e, rs1_d) || reg_hit(rd_e, rs2_d);
  assign d_hit_m = reg_hit(rd_m, rs1_d) || reg_hit(rd_m, rs2_d);

  // Without forwarding, any in-flight E/M producer blocks D; W is covered by write-first RF.
  assign raw_stall = (mem_read_e && d_hit_e)
                   || (branch_d && ((reg_write_e && d_hit_e) || (mem_read_m && d_hit_m)))
                   || (!FWD_EN && ((reg_write_e && d_hit_e) || (reg_write_m && d_hit_m)));

  always_comb begin
    cnt_next  = cnt;
    mdu_stall = 1'b0;
    if (cnt == '0) begin
      if (mdu_op_e && (MDU_LATENCY > 1)) begin
        cnt_next  = CNT_LOAD;
        mdu_stall = 1'b1;
      end
    end else if (cnt == CNT_W'(1)) begin
      cnt_next = '0;
    end else begin
      cnt_next  = cnt - CNT_W'(1);
      mdu_stall = 1'b1;
    end
    // Reset must release the pipeline immediately, even with an MDU op still in E.
    if (rst) mdu_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end

  always_comb begin
    forward_a = FWD_REG;
    forward_b = FWD_REG;
    if (FWD_EN) begin
      forward_a = fwd_sel(rs1_e);
      forward_b = fwd_sel(rs2_e);
    end
  end

  assign stall_f  = mdu_stall || raw_stall;
  assign stall_d  = mdu_stall || raw_stall;
  assign stall_e  = mdu_stall;
  assign flush_m  = mdu_stall;
  assign flush_e  = raw_stall && !mdu_stall;
  assign flush_d  = pcsrc_d && !stall_d;
  assign mdu_done = !rst && mdu_op_e && ((cnt == CNT_W'(1)) || (MDU_LATENCY == 1));

  hazard_sat_counter #(.PERF_W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_d),
    .count (stall_cnt)
  );

  hazard_sat_counter #(.PERF_W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_d || flush_e),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: two configurations share one stimulus stream
// and are checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_control_unit;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1_d, rs2_d;
    logic       branch_d, pcsrc_d;
    logic [4:0] rs1_e, rs2_e, rd_e;
    logic       reg_write_e, mem_read_e, mdu_op_e;
    logic [4:0] rd_m;
    logic       reg_write_m, mem_read_m;
    logic [4:0] rd_w;
    logic       reg_write_w;
  } stim_t;

  typedef struct {
    int         inst;
    string      tag;
    logic [10:0] flags;   // stall_f stall_d stall_e flush_d flush_e flush_m mdu_done fwd_a fwd_b
    longint     scnt;
    longint     fcnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0, rd_e = '0, rd_m = '0, rd_w = '0;
  logic       branch_d = 0, pcsrc_d = 0, reg_write_e = 0, mem_read_e = 0, mdu_op_e = 0;
  logic       reg_write_m = 0, mem_read_m = 0, reg_write_w = 0;

  logic       stall_f_a, stall_d_a, stall_e_a, flush_d_a, flush_e_a, flush_m_a, mdu_done_a;
  logic [1:0] forward_a_a, forward_b_a;
  logic [31:0] stall_cnt_a, flush_cnt_a;
  logic       stall_f_b, stall_d_b, stall_e_b, flush_d_b, flush_e_b, flush_m_b, mdu_done_b;
  logic [1:0] forward_a_b, forward_b_b;
  logic [3:0] stall_cnt_b, flush_cnt_b;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(5), .MDU_LATENCY(4), .FWD_EN(1'b1), .PERF_W(32)) dut_a (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .branch_d(branch_d), .pcsrc_d(pcsrc_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
    .mdu_op_e(mdu_op_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_read_m(mem_read_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .stall_f(stall_f_a), .stall_d(stall_d_a),
    .stall_e(stall_e_a), .flush_d(flush_d_a), .flush_e(flush_e_a), .flush_m(flush_m_a),
    .forward_a(forward_a_a), .forward_b(forward_b_a), .mdu_done(mdu_done_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a));

  hazard_control_unit #(.REG_ADDR_W(5), .MDU_LATENCY(1), .FWD_EN(1'b0), .PERF_W(4)) dut_b (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .branch_d(branch_d), .pcsrc_d(pcsrc_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
    .mdu_op_e(mdu_op_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_read_m(mem_read_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .stall_f(stall_f_b), .stall_d(stall_d_b),
    .stall_e(stall_e_b), .flush_d(flush_d_b), .flush_e(flush_e_b), .flush_m(flush_m_b),
    .forward_a(forward_a_b), .forward_b(forward_b_b), .mdu_done(mdu_done_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b));

  // Model state per configuration: MDU op occupancy age, counters, last cycle's events.
  bit     active [2];
  int     age    [2];
  longint scnt   [2];
  longint fcnt   [2];
  bit     prev_sd [2];
  bit     prev_fl [2];
  stim_t  prev;
  bit     have_prev = 0;
  exp_t   sb_q[$];
  int     n_vec = 0;
  int     n_bad = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic longint max_of(input int i);
    return (i == 0) ? 64'hFFFF_FFFF : 64'd15;
  endfunction

  function automatic bit hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_of(input int i, input stim_t s, input logic [4:0] rs);
    if (i != 0) return 2'b00;
    if (s.reg_write_m && hit(s.rd_m, rs)) return 2'b10;
    if (s.reg_write_w && hit(s.rd_w, rs)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model_eval(input int i, input stim_t s, input string tag);
    exp_t e;
    int   lat = lat_of(i);
    bit   dep_e = hit(s.rd_e, s.rs1_d) || hit(s.rd_e, s.rs2_d);
    bit   dep_m = hit(s.rd_m, s.rs1_d) || hit(s.rd_m, s.rs2_d);
    bit   raw, busy, done, sd, fe, fd;
    raw = (s.mem_read_e && dep_e)
       || (s.branch_d && ((s.reg_write_e && dep_e) || (s.mem_read_m && dep_m)))
       || ((i != 0) && ((s.reg_write_e && dep_e) || (s.reg_write_m && dep_m)));
    busy = !s.rst && (lat > 1) && (active[i] ? (age[i] < lat - 1) : s.mdu_op_e);
    done = !s.rst && s.mdu_op_e && ((lat == 1) || (active[i] && age[i] == lat - 1));
    sd = busy || raw;
    fe = raw && !busy;
    fd = s.pcsrc_d && !sd;
    e.inst  = i;
    e.tag   = tag;
    e.flags = {sd, sd, busy, fd, fe, busy, done, fwd_of(i, s, s.rs1_e), fwd_of(i, s, s.rs2_e)};
    e.scnt  = scnt[i];
    e.fcnt  = fcnt[i];
    prev_sd[i] = sd;
    prev_fl[i] = fd || fe;
    return e;
  endfunction

  task automatic model_clock(input int i);
    int lat = lat_of(i);
    if (prev_sd[i] && scnt[i] < max_of(i)) scnt[i] = scnt[i] + 1;
    if (prev_fl[i] && fcnt[i] < max_of(i)) fcnt[i] = fcnt[i] + 1;
    if (lat > 1) begin
      if (active[i]) begin
        if (age[i] == lat - 1) active[i] = 0;
        else age[i] = age[i] + 1;
      end else if (prev.mdu_op_e) begin
        active[i] = 1;
        age[i] = 1;
      end
    end
  endtask

  task automatic cyc(input stim_t s, input string tag);
    @(posedge clk);
    if (have_prev && !prev.rst) for (int i = 0; i < 2; i++) model_clock(i);
    #1;
    rst = s.rst; rs1_d = s.rs1_d; rs2_d = s.rs2_d; branch_d = s.branch_d; pcsrc_d = s.pcsrc_d;
    rs1_e = s.rs1_e; rs2_e = s.rs2_e; rd_e = s.rd_e; reg_write_e = s.reg_write_e;
    mem_read_e = s.mem_read_e; mdu_op_e = s.mdu_op_e; rd_m = s.rd_m; reg_write_m = s.reg_write_m;
    mem_read_m = s.mem_read_m; rd_w = s.rd_w; reg_write_w = s.reg_write_w;
    if (s.rst) for (int i = 0; i < 2; i++) begin
      active[i] = 0; age[i] = 0; scnt[i] = 0; fcnt[i] = 0;
    end
    for (int i = 0; i < 2; i++) sb_q.push_back(model_eval(i, s, tag));
    prev = s;
    have_prev = 1;
  endtask

  // Monitor: outputs are combinational, so every cycle presents one response per instance.
  initial begin
    exp_t        e;
    logic [10:0] act;
    longint      as, af;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.inst == 0) begin
          act = {stall_f_a, stall_d_a, stall_e_a, flush_d_a, flush_e_a, flush_m_a, mdu_done_a,
                 forward_a_a, forward_b_a};
          as = longint'(stall_cnt_a);
          af = longint'(flush_cnt_a);
        end else begin
          act = {stall_f_b, stall_d_b, stall_e_b, flush_d_b, flush_e_b, flush_m_b, mdu_done_b,
                 forward_a_b, forward_b_b};
          as = longint'(stall_cnt_b);
          af = longint'(flush_cnt_b);
        end
        n_vec++;
        if (act !== e.flags || as != e.scnt || af != e.fcnt) begin
          n_bad++;
          $display("FAIL %s inst%0d t=%0t: flags got %b want %b, stall_cnt got %0d want %0d, flush_cnt got %0d want %0d",
                   e.tag, e.inst, $time, act, e.flags, as, e.scnt, af, e.fcnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    bit    mdu_hold = 0;

    s = '0; s.rst = 1;
    repeat (2) cyc(s, "reset");

    s = '0; s.rs1_e = 5; s.rd_m = 5; s.reg_write_m = 1; s.rd_w = 5; s.reg_write_w = 1;
    cyc(s, "fwd_m_over_w");
    s.reg_write_m = 0;
    cyc(s, "fwd_w");
    s.reg_write_m = 1; s.rs1_e = 0; s.rs2_e = 5;
    cyc(s, "fwd_x0");

    s = '0; s.mem_read_e = 1; s.rd_e = 7; s.rs2_d = 7;
    cyc(s, "load_use");
    s = '0;
    cyc(s, "load_use_after");

    s = '0; s.mdu_op_e = 1;
    repeat (4) cyc(s, "mdu_single");
    s = '0;
    cyc(s, "mdu_idle");
    s.mdu_op_e = 1;
    repeat (9) cyc(s, "mdu_b2b");
    s = '0;
    cyc(s, "mdu_idle2");

    s = '0; s.mem_read_e = 1; s.rd_e = 9; s.rs1_d = 9; s.pcsrc_d = 1;
    cyc(s, "pcsrc_with_load_use");
    s = '0; s.pcsrc_d = 1;
    cyc(s, "pcsrc_after");

    s = '0; s.reg_write_m = 1; s.rd_m = 3; s.rs1_d = 3; s.rs1_e = 3;
    repeat (3) cyc(s, "nofwd_stall");

    s = '0; s.mdu_op_e = 1;
    repeat (2) cyc(s, "mdu_pre_rst");
    s.rst = 1;
    cyc(s, "rst_mid_mdu");
    s.rst = 0;
    cyc(s, "mdu_after_rst");

    s = '0; s.rst = 1;
    cyc(s, "reset2");
    s = '0; s.mem_read_e = 1; s.rd_e = 7; s.rs2_d = 7;
    repeat (21) cyc(s, "saturate");

    for (int n = 0; n < 500; n++) begin
      s = '0;
      if ($urandom_range(0, 3) == 0) mdu_hold = !mdu_hold;
      s.rst         = ($urandom_range(0, 99) == 0);
      s.rs1_d       = 5'($urandom_range(0, 7));
      s.rs2_d       = 5'($urandom_range(0, 7));
      s.branch_d    = ($urandom_range(0, 3) == 0);
      s.pcsrc_d     = ($urandom_range(0, 3) == 0);
      s.rs1_e       = 5'($urandom_range(0, 7));
      s.rs2_e       = 5'($urandom_range(0, 7));
      s.rd_e        = 5'($urandom_range(0, 7));
      s.reg_write_e = 1'($urandom_range(0, 1));
      s.mem_read_e  = ($urandom_range(0, 3) == 0);
      s.mdu_op_e    = mdu_hold;
      s.rd_m        = 5'($urandom_range(0, 7));
      s.reg_write_m = 1'($urandom_range(0, 1));
      s.mem_read_m  = ($urandom_range(0, 3) == 0);
      s.rd_w        = 5'($urandom_range(0, 7));
      s.reg_write_w = 1'($urandom_range(0, 1));
      cyc(s, "random");
    end

    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses left unchecked, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
